mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one pipelined memory between an instruction fetch
// port and a data (load/store) port. One transaction in flight at a time.
// Data accesses normally win; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants that happened while fetch was waiting.
//
// Handshake (both ports): the requester raises *_req (level) with its address,
// write enable and write data stable, and keeps them until *_ready pulses high
// for exactly one cycle. Read data is valid with *_ready and held until the
// next capture for that port. Everything is latched at grant, so a requester
// may drop *_req or change its inputs after the grant without affecting the
// transaction in flight.
//
// Transaction timeline, with grant sampled in cycle g:
//   g        IDLE   request seen, winner chosen
//   g+1      ISSUE  ram_en/ram_we/ram_addr/ram_wdata presented
//   g+2..    WAIT   LAT cycles; ram_rdata captured in the last one (g+1+LAT)
//   g+2+LAT  DONE   ready pulse to the granted port, then back to IDLE
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  output logic              mem_stall,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LAT_CNT    = 4'(LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;
  logic       gnt_if;
  logic       gnt_we;
  logic       any_req;
  logic       pick_if;

  assign dbg_state = state;
  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = mem_req & ~mem_ready;

  // Arbitration: data first, unless fetch has waited through STARVE_MAX data grants.
  always_comb begin
    any_req = if_req | mem_req;
    pick_if = if_req & (~mem_req | (starve_cnt == STARVE_LIM));
  end

  // Transaction FSM with the memory strobes, latency counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      starve_cnt <= 4'd0;
      gnt_if     <= 1'b0;
      gnt_we     <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 32'd0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= 32'd0;
      mem_rdata  <= 32'd0;
    end else begin
      // Strobes and ready pulses are single-cycle; states that need them set them.
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state  <= S_ISSUE;
            ram_en <= 1'b1;
            gnt_if <= pick_if;
            if (pick_if) begin
              ram_addr   <= if_addr;
              gnt_we     <= 1'b0;
              starve_cnt <= 4'd0;
            end else begin
              ram_addr  <= mem_addr;
              ram_we    <= mem_we;
              ram_wdata <= mem_wdata;
              gnt_we    <= mem_we;
              if (if_req && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= LAT_CNT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          // Last wait cycle: read data from the ISSUE cycle is on ram_rdata now.
          if (cnt == 4'd1) begin
            state <= S_DONE;
            if (gnt_if) begin
              if_rdata <= ram_rdata;
              if_ready <= 1'b1;
            end else begin
              if (!gnt_we) begin
                mem_rdata <= ram_rdata;
              end
              mem_ready <= 1'b1;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed timing scenarios followed by a random
// phase with two independent requester drivers. Expected read data is pushed
// into per-port queues when a request is issued and popped by a monitor when
// the matching ready pulse appears.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int LAT        = 2;
  localparam int STARVE_MAX = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam int N_RAND  = 40;
  localparam int TIMEOUT = 300;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [31:0]       if_rdata;
  logic              if_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;
  logic              mem_stall;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int c0       = 0;
  logic rand_phase = 1'b0;

  logic [31:0] if_exp_q[$];
  logic [31:0] mem_exp_q[$];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  function automatic logic [31:0] rom_val(input logic [7:0] a);
    logic [7:0] m;
    m = a * 8'd37 + 8'd11;
    return {a, ~a, m, a ^ 8'hA5};
  endfunction

  logic [31:0] mem_arr [256];
  logic [31:0] pipe [LAT];
  logic        mem_clear;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int a = 0; a < 256; a++) mem_arr[a] <= rom_val(8'(a));
    end else if (pre_we) begin
      mem_arr[pre_addr] <= pre_data;
    end else if (ram_en && ram_we) begin
      mem_arr[ram_addr] <= ram_wdata;
    end
    pipe[0] <= ram_en ? mem_arr[ram_addr] : $urandom;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign ram_rdata = pipe[LAT-1];

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Land on the negedge of cycle k relative to c0.
  task automatic goto(input int k);
    while (cyc < c0 + k) next_cycle();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int   issue_cyc = 0;
  int   consec    = 0;
  logic prev_if   = 1'b0;
  logic prev_mem  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      consec   = 0;
      prev_if  = 1'b0;
      prev_mem = 1'b0;
    end else begin
      if (if_ready || mem_ready) check("ready_exclusive", {31'd0, if_ready & mem_ready}, 32'd0);
      if (if_ready) begin
        if (if_exp_q.size() == 0) check("if_ready_unexpected", {31'd0, if_ready}, 32'd0);
        else check("if_rdata", if_rdata, if_exp_q.pop_front());
        check("if_latency", 32'(cyc - issue_cyc), 32'(LAT + 1));
      end
      if (mem_ready) begin
        if (mem_exp_q.size() == 0) check("mem_ready_unexpected", {31'd0, mem_ready}, 32'd0);
        else check("mem_rdata", mem_rdata, mem_exp_q.pop_front());
        check("mem_latency", 32'(cyc - issue_cyc), 32'(LAT + 1));
      end
      if (ram_en) issue_cyc = cyc;
      if (rand_phase) begin
        if (if_req) check("if_stall", {31'd0, if_stall}, {31'd0, ~if_ready});
        if (mem_req) check("mem_stall", {31'd0, mem_stall}, {31'd0, ~mem_ready});
        // Fetch lives in 0..127 and data in 128..255 during this phase.
        if (ram_en) begin
          if (ram_addr[7]) begin
            if (prev_if) begin
              consec++;
              check("starve_bound", {31'd0, consec <= STARVE_MAX}, 32'd1);
            end
          end else begin
            check("fetch_beat_data", {31'd0, prev_mem && (consec < STARVE_MAX)}, 32'd0);
            consec = 0;
          end
        end
      end
      prev_if  = if_req;
      prev_mem = mem_req;
    end
  end

  // ---------------- random drivers ----------------
  task automatic fetch_driver();
    int gap;
    int n;
    logic [7:0] a;
    for (int i = 0; i < N_RAND; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        if_req = 1'b0;
        repeat (gap) next_cycle();
      end
      a = 8'($urandom_range(0, 127));
      if_addr = a;
      if_req  = 1'b1;
      if_exp_q.push_back(rom_val(a));
      n = 0;
      @(negedge clk);
      while (!if_ready && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      if (!if_ready) check("if_timeout", {31'd0, if_ready}, 32'd1);
      next_cycle();
    end
    if_req = 1'b0;
  endtask

  task automatic mem_driver();
    logic [31:0] shadow [256];
    logic [31:0] last_rd;
    int gap;
    int n;
    logic [7:0] a;
    for (int k = 0; k < 256; k++) shadow[k] = rom_val(8'(k));
    last_rd = 32'd0;
    for (int i = 0; i < N_RAND; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 0) begin
        mem_req = 1'b0;
        repeat (gap) next_cycle();
      end
      a = 8'($urandom_range(128, 255));
      mem_addr  = a;
      mem_we    = ($urandom_range(0, 2) == 0);
      mem_wdata = $urandom;
      mem_req   = 1'b1;
      if (mem_we) begin
        shadow[a] = mem_wdata;
        mem_exp_q.push_back(last_rd);
      end else begin
        last_rd = shadow[a];
        mem_exp_q.push_back(shadow[a]);
      end
      n = 0;
      @(negedge clk);
      while (!mem_ready && n < TIMEOUT) begin
        @(negedge clk);
        n++;
      end
      if (!mem_ready) check("mem_timeout", {31'd0, mem_ready}, 32'd1);
      next_cycle();
    end
    mem_req = 1'b0;
    mem_we  = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- directed + random sequence ----------------
  logic [7:0] order [6];

  initial begin
    rst = 1'b1; mem_clear = 1'b1; pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'd0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; mem_clear = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("rst_ram_en", {31'd0, ram_en}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {24'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", ram_wdata, 32'd0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    check("rst_stalls", {30'd0, if_stall, mem_stall}, 32'd0);

    // Fetch only
    next_cycle();
    preload(8'h10, 32'h00500093);
    c0 = cyc;
    if_req = 1'b1; if_addr = 8'h10;
    if_exp_q.push_back(32'h00500093);
    goto(0);
    check("f_stall_c0", {31'd0, if_stall}, 32'd1);
    check("f_ram_en_c0", {31'd0, ram_en}, 32'd0);
    goto(1);
    check("f_ram_en_c1", {31'd0, ram_en}, 32'd1);
    check("f_ram_addr_c1", {24'd0, ram_addr}, 32'h10);
    check("f_ram_we_c1", {31'd0, ram_we}, 32'd0);
    goto(2);
    check("f_ram_en_c2", {31'd0, ram_en}, 32'd0);
    goto(3);
    check("f_ready_c3", {31'd0, if_ready}, 32'd0);
    goto(4);
    check("f_ready_c4", {31'd0, if_ready}, 32'd1);
    check("f_rdata_c4", if_rdata, 32'h00500093);
    check("f_stall_c4", {31'd0, if_stall}, 32'd0);
    next_cycle();
    if_req = 1'b0;
    goto(5);
    check("f_ready_c5", {31'd0, if_ready}, 32'd0);
    check("f_rdata_hold", if_rdata, 32'h00500093);

    // Simultaneous fetch and load: data first
    next_cycle();
    preload(8'h20, 32'h12345678);
    preload(8'h11, 32'hCAFEF00D);
    c0 = cyc;
    if_req = 1'b1; if_addr = 8'h11;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h20;
    if_exp_q.push_back(32'hCAFEF00D);
    mem_exp_q.push_back(32'h12345678);
    goto(1);
    check("b_ram_addr_c1", {24'd0, ram_addr}, 32'h20);
    goto(4);
    check("b_mem_ready_c4", {31'd0, mem_ready}, 32'd1);
    check("b_if_ready_c4", {31'd0, if_ready}, 32'd0);
    next_cycle();
    mem_req = 1'b0;
    goto(6);
    check("b_ram_en_c6", {31'd0, ram_en}, 32'd1);
    check("b_ram_addr_c6", {24'd0, ram_addr}, 32'h11);
    goto(9);
    check("b_if_ready_c9", {31'd0, if_ready}, 32'd1);
    next_cycle();
    if_req = 1'b0;

    // Store: same timing as a load, mem_rdata untouched
    c0 = cyc;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h20; mem_wdata = 32'hDEADBEEF;
    mem_exp_q.push_back(32'h12345678);
    goto(1);
    check("s_ram_en_c1", {31'd0, ram_en}, 32'd1);
    check("s_ram_we_c1", {31'd0, ram_we}, 32'd1);
    check("s_ram_addr_c1", {24'd0, ram_addr}, 32'h20);
    check("s_ram_wdata_c1", ram_wdata, 32'hDEADBEEF);
    goto(2);
    check("s_ram_en_c2", {31'd0, ram_en}, 32'd0);
    check("s_ram_we_c2", {31'd0, ram_we}, 32'd0);
    goto(4);
    check("s_mem_ready_c4", {31'd0, mem_ready}, 32'd1);
    next_cycle();
    mem_req = 1'b0; mem_we = 1'b0;

    // Both held continuously: grant order mem, mem, if, mem, mem, if
    preload(8'h30, 32'h00003030);
    preload(8'h40, 32'h00004040);
    c0 = cyc;
    if_req = 1'b1; if_addr = 8'h30;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
    repeat (4) mem_exp_q.push_back(32'h00004040);
    repeat (2) if_exp_q.push_back(32'h00003030);
    order[0] = 8'h40; order[1] = 8'h40; order[2] = 8'h30;
    order[3] = 8'h40; order[4] = 8'h40; order[5] = 8'h30;
    for (int k = 0; k < 6; k++) begin
      goto(1 + k * (LAT + 3));
      check("order_ram_en", {31'd0, ram_en}, 32'd1);
      check("order_ram_addr", {24'd0, ram_addr}, {24'd0, order[k]});
    end
    goto(6 * (LAT + 3) - 1);
    next_cycle();
    if_req = 1'b0; mem_req = 1'b0;

    // Request dropped and inputs changed mid-transaction
    c0 = cyc;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
    mem_exp_q.push_back(32'h00004040);
    goto(1);
    check("d_ram_en_c1", {31'd0, ram_en}, 32'd1);
    next_cycle();
    mem_req = 1'b0; mem_addr = 8'hFF; mem_we = 1'b1;
    goto(4);
    check("d_mem_ready_c4", {31'd0, mem_ready}, 32'd1);
    goto(5);
    check("d_ram_en_c5", {31'd0, ram_en}, 32'd0);
    check("d_mem_ready_c5", {31'd0, mem_ready}, 32'd0);
    mem_we = 1'b0;

    // Reset during WAIT aborts the fetch; still-high request is regranted
    next_cycle();
    c0 = cyc;
    if_req = 1'b1; if_addr = 8'h10;
    if_exp_q.push_back(32'h00500093);
    goto(1);
    check("r_ram_en_c1", {31'd0, ram_en}, 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    goto(3);
    check("r_state_c3", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    check("r_ram_en_c3", {31'd0, ram_en}, 32'd0);
    check("r_if_ready_c3", {31'd0, if_ready}, 32'd0);
    check("r_if_rdata_c3", if_rdata, 32'd0);
    goto(4);
    check("r_ram_en_c4", {31'd0, ram_en}, 32'd1);
    check("r_ram_addr_c4", {24'd0, ram_addr}, 32'h10);
    goto(6);
    check("r_if_ready_c6", {31'd0, if_ready}, 32'd0);
    goto(7);
    check("r_if_ready_c7", {31'd0, if_ready}, 32'd1);
    next_cycle();
    if_req = 1'b0;

    // Random phase from a clean reset
    next_cycle();
    rst = 1'b1; mem_clear = 1'b1;
    next_cycle();
    rst = 1'b0; mem_clear = 1'b0;
    rand_phase = 1'b1;
    fork
      fetch_driver();
      mem_driver();
    join
    repeat (LAT + 4) next_cycle();
    rand_phase = 1'b0;
    check("if_queue_drained", 32'(if_exp_q.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
